irq_flag_unit: RTL and testbench
================================

Name: irq_flag_unit

Overview:
- Interrupt-flag (IF, 0xFF0F) block directly upstream of SM83Core.
- Captures peripheral interrupt events into five sticky flag bits and drives them onto the core's CPU_IRQ_TRIG bus.
- Clears flags on the core's CPU_IRQ_ACK pulses and provides the CPU read/write port for the IF register.
- Sits between the peripheral blocks (PPU, timer, serial, joypad pins) and the core.

Parameters:
- NUM_IRQ, 5, number of implemented flag bits; CPU_IRQ_TRIG bits above NUM_IRQ-1 are tied 0.
- JOYP_SYNC_STAGES, 2, synchronizer depth for the asynchronous joypad pins.

Ports:
- CLK  input  1  single system clock; all state updates on its rising edge.
- nRESET  input  1  asynchronous, active-low reset.
- IRQ_VBLANK  input  1  level from PPU; rising edge requests bit 0.
- IRQ_STAT  input  1  level from PPU STAT logic; rising edge requests bit 1.
- IRQ_TIMER  input  1  level from timer; rising edge requests bit 2.
- IRQ_SERIAL  input  1  level from serial port; rising edge requests bit 3.
- nJOYP  input  4  raw P10..P13 pins, active-low, asynchronous; any falling edge requests bit 4.
- IF_SEL  input  1  address decode hit for 0xFF0F, from the bus decoder.
- RD  input  1  CPU read strobe.
- WR  input  1  CPU write strobe; may be held for several cycles.
- DIN  input  8  CPU write data.
- DOUT  output  8  IF read data.
- DOUT_EN  output  1  drive enable for DOUT onto the data bus.
- CPU_IRQ_ACK  input  8  from core; a high bit clears the matching flag.
- CPU_IRQ_TRIG  output  8  to core; registered flag vector.

Behaviour:
- Reset (nRESET low, asynchronous):
  - IF[4:0]=0, CPU_IRQ_TRIG=0.
  - Source-previous registers set to 1, so a source already high at reset release raises no request.
  - Joypad sync chain and its previous register set to 4'b1111.
  - DOUT_EN=0.
- Edge detection, bits 0..3:
  - req[i] = src & ~src_q; src_q <= src every cycle.
  - Flag sets on the same edge the rise is first sampled, so CPU_IRQ_TRIG goes high 1 cycle after the source is first seen high.
  - A source held high produces exactly one request.
- Joypad, bit 4:
  - nJOYP passes through JOYP_SYNC_STAGES flops, then falling-edge detect per pin; the four results are ORed.
  - Latency from pin low to TRIG high is JOYP_SYNC_STAGES+1 cycles (3 at default).
  - Glitches shorter than one cycle are not guaranteed to register.
- CPU write:
  - Write strobe = IF_SEL & WR & ~wr_q (first cycle of WR only).
  - On the strobe, IF[4:0] <= DIN[4:0]; DIN[7:5] is ignored.
  - Holding WR does not repeat the write, so source sets during a long WR are not lost.
- Next-state priority, per bit, lowest to highest:
  - hold;
  - ACK clear (IF[i] & ~CPU_IRQ_ACK[i]);
  - CPU write value (overrides ACK);
  - source set (ORed last).
  - A new request coinciding with an ACK or a write of 0 leaves the bit at 1.
- ACK:
  - Level-sensitive; clears the flag every cycle the bit is high.
  - Multiple ACK bits high clear all of them.
  - ACK bits 7..5 are ignored.
- CPU_IRQ_TRIG = {3'b000, IF[4:0]}, registered with no combinational path from the inputs.
- Read:
  - Combinational. DOUT_EN = IF_SEL & RD.
  - DOUT = {3'b111, IF[4:0]} when DOUT_EN is high, else 8'h00.
  - A read returns the pre-edge value even when the register updates on that edge.
- RD and WR asserted together: the write proceeds and the read shows the old value.
- nRESET asserted mid-write or mid-pending: all state returns to its reset values at once; no request survives.

Decomposition:
- Shared package irq_pkg:
  - bit-index constants IRQ_BIT_VBLANK=0, IRQ_BIT_STAT=1, IRQ_BIT_TIMER=2, IRQ_BIT_SERIAL=3, IRQ_BIT_JOYPAD=4;
  - IF_ADDR=16'hFF0F;
  - IF_UNUSED_READ=3'b111.
- One natural sub-module, irq_edge_det:
  - parameterised width and polarity;
  - async-low reset to a parameter value;
  - used once for bits 0..3 (rising) and once for the joypad pins (falling, after the synchronizer).

Test Plan:
- Reset release with IRQ_TIMER held high -> CPU_IRQ_TRIG stays 8'h00 for 10 cycles; then pulse IRQ_TIMER low and high again -> TRIG=8'h04 one cycle after the rise.
- IRQ_VBLANK rises at cycle n, CPU_IRQ_ACK=8'h01 at cycle n+3 -> TRIG=8'h01 in cycles n+1..n+3, then 8'h00 from n+4; a read returns 8'hE0 afterwards.
- ACK=8'h02 in the same cycle IRQ_STAT rises, with bit 1 already set -> bit 1 remains 1 and TRIG=8'h02.
- IF_SEL&WR held 4 cycles with DIN=8'hFF, IRQ_SERIAL rising in cycle 3 -> IF=5'h1F after the first edge and stays 5'h1F; read gives 8'hFF. Then write DIN=8'h00 -> TRIG=8'h00.
- nJOYP=4'b1111 -> 4'b1011 at cycle n -> TRIG bit 4 set at cycle n+3; holding the pin low raises no second request after ACK 8'h10.
- nRESET pulsed low with IF=5'h15 -> TRIG=8'h00 immediately (asynchronous); read after release gives 8'hE0.

Source files
------------

// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared constants and helpers for the interrupt-flag block
package irq_pkg;

  localparam int IRQ_BIT_VBLANK = 0;
  localparam int IRQ_BIT_STAT   = 1;
  localparam int IRQ_BIT_TIMER  = 2;
  localparam int IRQ_BIT_SERIAL = 3;
  localparam int IRQ_BIT_JOYPAD = 4;

  localparam int IRQ_FLAG_BITS  = IRQ_BIT_JOYPAD + 1;
  localparam int IRQ_LEVEL_SRCS = 4;
  localparam int JOYP_PINS      = 4;

  localparam logic [15:0] IF_ADDR        = 16'hFF0F;
  localparam logic [2:0]  IF_UNUSED_READ = 3'b111;

  typedef logic [IRQ_FLAG_BITS-1:0] irq_flags_t;

  // Unimplemented IF bits read back as ones on the real part.
  function automatic logic [7:0] if_read_word(input irq_flags_t flags);
    return {IF_UNUSED_READ, flags};
  endfunction

endpackage

// File: rtl/irq_flag_unit_if.sv
// rtl/irq_flag_unit_if.sv - CPU register port and core IRQ handshake for the IF block
interface irq_flag_unit_if;

  logic       IF_SEL;
  logic       RD;
  logic       WR;
  logic [7:0] DIN;
  logic [7:0] DOUT;
  logic       DOUT_EN;
  logic [7:0] CPU_IRQ_ACK;
  logic [7:0] CPU_IRQ_TRIG;

  modport master (
    output IF_SEL,
    output RD,
    output WR,
    output DIN,
    output CPU_IRQ_ACK,
    input  DOUT,
    input  DOUT_EN,
    input  CPU_IRQ_TRIG
  );

  modport slave (
    input  IF_SEL,
    input  RD,
    input  WR,
    input  DIN,
    input  CPU_IRQ_ACK,
    output DOUT,
    output DOUT_EN,
    output CPU_IRQ_TRIG
  );

endinterface

// File: rtl/irq_edge_det.sv
// rtl/irq_edge_det.sv - per-bit edge detector with configurable polarity and reset level
module irq_edge_det #(
  parameter int               WIDTH     = 1,
  parameter bit               RISING    = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] pulse
);

  logic [WIDTH-1:0] level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= RESET_VAL;
    end else begin
      level_q <= level;
    end
  end

  // Reset value matching the idle level suppresses a spurious edge at reset release.
  assign pulse = RISING ? (level & ~level_q) : (~level & level_q);

endmodule

// File: rtl/irq_flag_unit.sv
// rtl/irq_flag_unit.sv - IF register: sticky interrupt flags feeding the core
module irq_flag_unit
  import irq_pkg::*;
#(
  parameter int NUM_IRQ          = 5,
  parameter int JOYP_SYNC_STAGES = 2
) (
  input  logic                 CLK,
  input  logic                 nRESET,
  input  logic                 IRQ_VBLANK,
  input  logic                 IRQ_STAT,
  input  logic                 IRQ_TIMER,
  input  logic                 IRQ_SERIAL,
  input  logic [JOYP_PINS-1:0] nJOYP,
  irq_flag_unit_if.slave       bus
);

  localparam irq_flags_t IRQ_MASK = IRQ_FLAG_BITS'((32'd1 << NUM_IRQ) - 32'd1);

  logic [IRQ_LEVEL_SRCS-1:0] src_level;
  logic [IRQ_LEVEL_SRCS-1:0] src_pulse;
  logic [JOYP_PINS-1:0]      joyp_sync [JOYP_SYNC_STAGES];
  logic [JOYP_PINS-1:0]      joyp_pulse;
  irq_flags_t                irq_req;
  irq_flags_t                if_q;
  irq_flags_t                if_nxt;
  logic                      wr_q;
  logic                      wr_stb;
  logic                      unused_bus_bits;

  assign src_level = {IRQ_SERIAL, IRQ_TIMER, IRQ_STAT, IRQ_VBLANK};

  irq_edge_det #(
    .WIDTH     (IRQ_LEVEL_SRCS),
    .RISING    (1'b1),
    .RESET_VAL ({IRQ_LEVEL_SRCS{1'b1}})
  ) u_src_edge (
    .clk   (CLK),
    .rst_n (nRESET),
    .level (src_level),
    .pulse (src_pulse)
  );

  // Joypad pins are asynchronous; resync before edge detection.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      for (int s = 0; s < JOYP_SYNC_STAGES; s++) begin
        joyp_sync[s] <= '1;
      end
    end else begin
      joyp_sync[0] <= nJOYP;
      for (int s = 1; s < JOYP_SYNC_STAGES; s++) begin
        joyp_sync[s] <= joyp_sync[s-1];
      end
    end
  end

  irq_edge_det #(
    .WIDTH     (JOYP_PINS),
    .RISING    (1'b0),
    .RESET_VAL ({JOYP_PINS{1'b1}})
  ) u_joyp_edge (
    .clk   (CLK),
    .rst_n (nRESET),
    .level (joyp_sync[JOYP_SYNC_STAGES-1]),
    .pulse (joyp_pulse)
  );

  always_comb begin
    irq_req                 = '0;
    irq_req[IRQ_BIT_VBLANK] = src_pulse[IRQ_BIT_VBLANK];
    irq_req[IRQ_BIT_STAT]   = src_pulse[IRQ_BIT_STAT];
    irq_req[IRQ_BIT_TIMER]  = src_pulse[IRQ_BIT_TIMER];
    irq_req[IRQ_BIT_SERIAL] = src_pulse[IRQ_BIT_SERIAL];
    irq_req[IRQ_BIT_JOYPAD] = |joyp_pulse;
  end

  // Only the first cycle of a held WR writes, so requests arriving later survive.
  assign wr_stb = bus.IF_SEL & bus.WR & ~wr_q;

  always_comb begin
    if_nxt = if_q & ~bus.CPU_IRQ_ACK[IRQ_FLAG_BITS-1:0];
    if (wr_stb) begin
      if_nxt = bus.DIN[IRQ_FLAG_BITS-1:0];
    end
    if_nxt = (if_nxt | irq_req) & IRQ_MASK;
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      if_q <= '0;
      wr_q <= 1'b0;
    end else begin
      if_q <= if_nxt;
      wr_q <= bus.WR;
    end
  end

  assign bus.CPU_IRQ_TRIG = {{(8 - IRQ_FLAG_BITS){1'b0}}, if_q};
  assign bus.DOUT_EN      = bus.IF_SEL & bus.RD;
  assign bus.DOUT         = bus.DOUT_EN ? if_read_word(if_q) : 8'h00;

  assign unused_bus_bits = ^{bus.DIN[7:IRQ_FLAG_BITS], bus.CPU_IRQ_ACK[7:IRQ_FLAG_BITS]};

endmodule

// File: tb/tb_irq_flag_unit.sv
// tb/tb_irq_flag_unit.sv - self-checking bench for irq_flag_unit
module tb_irq_flag_unit;

  localparam int STAGES = 2;

  logic       CLK = 1'b0;
  logic       nRESET = 1'b1;
  logic       IRQ_VBLANK, IRQ_STAT, IRQ_TIMER, IRQ_SERIAL;
  logic [3:0] nJOYP;

  irq_flag_unit_if bus ();

  irq_flag_unit #(
    .NUM_IRQ          (5),
    .JOYP_SYNC_STAGES (STAGES)
  ) dut (
    .CLK        (CLK),
    .nRESET     (nRESET),
    .IRQ_VBLANK (IRQ_VBLANK),
    .IRQ_STAT   (IRQ_STAT),
    .IRQ_TIMER  (IRQ_TIMER),
    .IRQ_SERIAL (IRQ_SERIAL),
    .nJOYP      (nJOYP),
    .bus        (bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: flag bits, last seen source levels, last WR, joypad pin history.
  logic [4:0] m_flags;
  logic [3:0] m_src_prev;
  logic       m_wr_prev;
  logic [3:0] m_pins [$];

  typedef struct {
    logic [3:0] src;
    logic       sel;
    logic       rd;
    logic       wr;
    logic [7:0] din;
    logic [7:0] ack;
    logic [7:0] exp_dout;
    logic [7:0] exp_trig;
  } vec_t;

  vec_t vecs [14];

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  task automatic model_reset();
    m_flags    = 5'h00;
    m_src_prev = 4'hF;
    m_wr_prev  = 1'b0;
    m_pins.delete();
    for (int i = 0; i <= STAGES; i++) m_pins.push_back(4'hF);
  endtask

  // A pin counts as pressed once its low level has crossed the synchronizer.
  task automatic model_edge();
    logic [3:0] src;
    logic [4:0] req;
    logic       wr_strobe;
    src = {IRQ_SERIAL, IRQ_TIMER, IRQ_STAT, IRQ_VBLANK};
    for (int b = 0; b < 4; b++) req[b] = src[b] && !m_src_prev[b];
    req[4] = 1'b0;
    for (int p = 0; p < 4; p++)
      if (m_pins[STAGES][p] && !m_pins[STAGES-1][p]) req[4] = 1'b1;
    wr_strobe = bus.IF_SEL && bus.WR && !m_wr_prev;
    for (int b = 0; b < 5; b++) begin
      if (req[b])                   m_flags[b] = 1'b1;
      else if (wr_strobe)           m_flags[b] = bus.DIN[b];
      else if (bus.CPU_IRQ_ACK[b])  m_flags[b] = 1'b0;
    end
    m_src_prev = src;
    m_wr_prev  = bus.WR;
    m_pins.push_front(nJOYP);
    void'(m_pins.pop_back());
  endtask

  task automatic tick();
    #1;
    check8("dout", bus.DOUT, (bus.IF_SEL && bus.RD) ? {3'b111, m_flags} : 8'h00);
    check8("dout_en", {7'b0, bus.DOUT_EN}, {7'b0, bus.IF_SEL && bus.RD});
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    check8("trig", bus.CPU_IRQ_TRIG, {3'b000, m_flags});
  endtask

  task automatic idle_inputs();
    IRQ_VBLANK = 0; IRQ_STAT = 0; IRQ_TIMER = 0; IRQ_SERIAL = 0;
    nJOYP = 4'hF;
    bus.IF_SEL = 0; bus.RD = 0; bus.WR = 0; bus.DIN = 8'h00; bus.CPU_IRQ_ACK = 8'h00;
  endtask

  task automatic clear_all();
    idle_inputs();
    repeat (STAGES + 1) tick();
    bus.IF_SEL = 1; bus.WR = 1; bus.DIN = 8'h00;
    tick();
    bus.IF_SEL = 0; bus.WR = 0;
    tick();
  endtask

  initial begin
    vecs[0]  = '{4'b0001, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h01};
    vecs[1]  = '{4'b0001, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'hE1, 8'h01};
    vecs[2]  = '{4'b0011, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h03};
    vecs[3]  = '{4'b0011, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 8'h00, 8'h02};
    vecs[4]  = '{4'b0011, 1'b1, 1'b1, 1'b1, 8'hFC, 8'h00, 8'hE2, 8'h1C};
    vecs[5]  = '{4'b0011, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h1C};
    vecs[6]  = '{4'b0011, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 8'h00, 8'h00};
    vecs[7]  = '{4'b1111, 1'b0, 1'b0, 1'b0, 8'h00, 8'h04, 8'h00, 8'h0C};
    vecs[8]  = '{4'b1100, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[9]  = '{4'b1101, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h01};
    vecs[10] = '{4'b1101, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'hE1, 8'h01};
    vecs[11] = '{4'b1111, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h02};
    vecs[12] = '{4'b0000, 1'b1, 1'b1, 1'b0, 8'h00, 8'h02, 8'hE2, 8'h00};
    vecs[13] = '{4'b0000, 1'b0, 1'b1, 1'b1, 8'h1F, 8'h00, 8'h00, 8'h00};

    // Reset with IRQ_TIMER already high: no request at release.
    idle_inputs();
    IRQ_TIMER = 1;
    #1 nRESET = 0;
    #1;
    check8("reset_trig", bus.CPU_IRQ_TRIG, 8'h00);
    check8("reset_dout_en", {7'b0, bus.DOUT_EN}, 8'h00);
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    nRESET = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check8("timer_held_no_irq", bus.CPU_IRQ_TRIG, 8'h00);
    end
    IRQ_TIMER = 0;
    tick();
    IRQ_TIMER = 1;
    tick();
    check8("timer_rise", bus.CPU_IRQ_TRIG, 8'h04);

    // Table-driven vectors from a clean state.
    clear_all();
    foreach (vecs[i]) begin
      {IRQ_SERIAL, IRQ_TIMER, IRQ_STAT, IRQ_VBLANK} = vecs[i].src;
      bus.IF_SEL = vecs[i].sel; bus.RD = vecs[i].rd; bus.WR = vecs[i].wr;
      bus.DIN = vecs[i].din; bus.CPU_IRQ_ACK = vecs[i].ack;
      #1;
      check8($sformatf("vec%0d_dout", i), bus.DOUT, vecs[i].exp_dout);
      tick();
      check8($sformatf("vec%0d_trig", i), bus.CPU_IRQ_TRIG, vecs[i].exp_trig);
    end

    // VBLANK rise then ACK three cycles later.
    clear_all();
    IRQ_VBLANK = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check8("vblank_pending", bus.CPU_IRQ_TRIG, 8'h01);
    end
    bus.CPU_IRQ_ACK = 8'h01;
    tick();
    check8("vblank_acked", bus.CPU_IRQ_TRIG, 8'h00);
    bus.CPU_IRQ_ACK = 8'h00; bus.IF_SEL = 1; bus.RD = 1;
    #1 check8("vblank_read", bus.DOUT, 8'hE0);
    tick();

    // ACK coinciding with a fresh STAT rise keeps the bit.
    clear_all();
    IRQ_STAT = 1; tick();
    IRQ_STAT = 0; tick();
    check8("stat_set", bus.CPU_IRQ_TRIG, 8'h02);
    IRQ_STAT = 1; bus.CPU_IRQ_ACK = 8'h02; tick();
    check8("stat_ack_collide", bus.CPU_IRQ_TRIG, 8'h02);
    bus.CPU_IRQ_ACK = 8'h00;

    // Long write with a SERIAL rise in the third cycle.
    clear_all();
    bus.IF_SEL = 1; bus.WR = 1; bus.DIN = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) IRQ_SERIAL = 1;
      tick();
      check8("long_wr", bus.CPU_IRQ_TRIG, 8'h1F);
    end
    bus.WR = 0; bus.RD = 1;
    #1 check8("long_wr_read", bus.DOUT, 8'hFF);
    tick();
    bus.RD = 0; bus.WR = 1; bus.DIN = 8'h00;
    tick();
    check8("write_zero", bus.CPU_IRQ_TRIG, 8'h00);

    // Joypad press latency and single request while held.
    clear_all();
    nJOYP = 4'b1011;
    tick(); check8("joy_lat1", bus.CPU_IRQ_TRIG, 8'h00);
    tick(); check8("joy_lat2", bus.CPU_IRQ_TRIG, 8'h00);
    tick(); check8("joy_lat3", bus.CPU_IRQ_TRIG, 8'h10);
    bus.CPU_IRQ_ACK = 8'h10; tick();
    check8("joy_ack", bus.CPU_IRQ_TRIG, 8'h00);
    bus.CPU_IRQ_ACK = 8'h00;
    repeat (5) begin
      tick(); check8("joy_held", bus.CPU_IRQ_TRIG, 8'h00);
    end
    nJOYP = 4'hF;
    repeat (4) begin
      tick(); check8("joy_release", bus.CPU_IRQ_TRIG, 8'h00);
    end

    // Asynchronous reset with flags set and a joypad press in flight.
    clear_all();
    bus.IF_SEL = 1; bus.WR = 1; bus.DIN = 8'h15; tick();
    check8("pre_reset", bus.CPU_IRQ_TRIG, 8'h15);
    bus.IF_SEL = 0; bus.WR = 0; nJOYP = 4'b1110; tick();
    #2 nRESET = 0; nJOYP = 4'hF;
    #1 check8("async_reset", bus.CPU_IRQ_TRIG, 8'h00);
    model_reset();
    @(posedge CLK);
    @(negedge CLK);
    nRESET = 1;
    bus.IF_SEL = 1; bus.RD = 1;
    #1 check8("post_reset_read", bus.DOUT, 8'hE0);
    tick();
    repeat (4) begin
      tick(); check8("post_reset_quiet", bus.CPU_IRQ_TRIG, 8'h00);
    end

    // Randomized traffic against the reference model.
    idle_inputs();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(3) == 0) IRQ_VBLANK = ~IRQ_VBLANK;
      if ($urandom_range(3) == 0) IRQ_STAT   = ~IRQ_STAT;
      if ($urandom_range(3) == 0) IRQ_TIMER  = ~IRQ_TIMER;
      if ($urandom_range(3) == 0) IRQ_SERIAL = ~IRQ_SERIAL;
      for (int p = 0; p < 4; p++)
        if ($urandom_range(7) == 0) nJOYP[p] = ~nJOYP[p];
      bus.IF_SEL = 1'($urandom_range(1));
      bus.RD     = 1'($urandom_range(1));
      if ($urandom_range(2) == 0) bus.WR = ~bus.WR;
      bus.DIN = 8'($urandom);
      bus.CPU_IRQ_ACK = ($urandom_range(3) == 0) ? 8'($urandom) : 8'h00;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
